// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide sequencer owning HI/LO: shift-add multiply and restoring divide.
// Define MDU_DIV_EN to build the divide datapath; without it DIV/DIVU are ignored (still stalled while busy).
module mdu_sequencer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_valid,
   input  logic [2:0]            i_op,
   input  logic [DATA_WIDTH-1:0] i_opA,
   input  logic [DATA_WIDTH-1:0] i_opB,
   input  logic                  i_read_hilo,
   output logic                  o_busy,
   output logic                  o_stall,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_hi,
   output logic [DATA_WIDTH-1:0] o_lo
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2*W-1:0]  acc_q, acc_d;
   logic [W-1:0]    mcand_q, mcand_d;
   logic [W-1:0]    hi_q, hi_d;
   logic [W-1:0]    lo_q, lo_d;
   logic            neg_q, neg_d;
   logic            done_q, done_d;

   logic            is_mul_op, is_div_cmd, is_div_op, is_mt_op, is_cmd, is_signed, accept;
   logic [W-1:0]    a_abs, b_abs;
   logic [W:0]      mul_sum;
   logic [2*W-1:0]  mul_next, prod;

   assign is_mul_op  = (i_op == OP_MULT) | (i_op == OP_MULTU);
   assign is_div_cmd = (i_op == OP_DIV) | (i_op == OP_DIVU);
   assign is_mt_op   = (i_op == OP_MTHI) | (i_op == OP_MTLO);
   assign is_cmd     = is_mul_op | is_div_cmd | is_mt_op;
   assign is_signed  = (i_op == OP_MULT) | (i_op == OP_DIV);
`ifdef MDU_DIV_EN
   assign is_div_op  = is_div_cmd;
`else
   assign is_div_op  = 1'b0;
`endif

   assign o_busy  = (state_q != S_IDLE);
   assign accept  = i_valid & (is_mul_op | is_div_op | is_mt_op) & ~o_busy;
   // Disabled DIV/DIVU still hold in EX while busy so ordering with HI/LO stays intact.
   assign o_stall = (o_busy & i_valid & is_cmd) | (o_busy & i_read_hilo);

   assign a_abs = (is_signed & i_opA[W-1]) ? -i_opA : i_opA;
   assign b_abs = (is_signed & i_opB[W-1]) ? -i_opB : i_opB;

   assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
   assign mul_next = {mul_sum, acc_q[W-1:1]};
   assign prod     = neg_q ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
   logic            is_div_q, is_div_d;
   logic            neg_rem_q, neg_rem_d;
   logic            dzero_q, dzero_d;
   logic [W:0]      div_sh, div_diff;
   logic [2*W-1:0]  div_next;

   // Remainder is widened by one bit so the bit shifted out of it takes part in the trial subtract.
   assign div_sh   = acc_q[2*W-1:W-1];
   assign div_diff = div_sh - {1'b0, mcand_q};
   assign div_next = div_diff[W] ? {div_sh[W-1:0], acc_q[W-2:0], 1'b0}
                                 : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      neg_d   = neg_q;
      done_d  = 1'b0;
`ifdef MDU_DIV_EN
      is_div_d  = is_div_q;
      neg_rem_d = neg_rem_q;
      dzero_d   = dzero_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (i_op == OP_MTHI) begin
                  hi_d = i_opA;
               end else if (i_op == OP_MTLO) begin
                  lo_d = i_opA;
               end else if (is_mul_op) begin
                  acc_d   = {{W{1'b0}}, b_abs};
                  mcand_d = a_abs;
                  neg_d   = is_signed & (i_opA[W-1] ^ i_opB[W-1]);
                  cnt_d   = CW'(W - 1);
                  state_d = S_RUN;
`ifdef MDU_DIV_EN
                  is_div_d = 1'b0;
               end else begin
                  acc_d     = {{W{1'b0}}, a_abs};
                  mcand_d   = b_abs;
                  neg_d     = is_signed & (i_opA[W-1] ^ i_opB[W-1]);
                  neg_rem_d = is_signed & i_opA[W-1];
                  dzero_d   = (i_opB == '0);
                  is_div_d  = 1'b1;
                  cnt_d     = CW'(W - 1);
                  state_d   = S_RUN;
`endif
               end
            end
         end
         S_RUN: begin
`ifdef MDU_DIV_EN
            acc_d = is_div_q ? div_next : mul_next;
`else
            acc_d = mul_next;
`endif
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_FIX: begin
            {hi_d, lo_d} = prod;
`ifdef MDU_DIV_EN
            if (is_div_q) begin
               hi_d = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
               lo_d = dzero_q ? {W{1'b1}} : (neg_q ? -acc_q[W-1:0] : acc_q[W-1:0]);
            end
`endif
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_q   <= 1'b0;
         done_q  <= 1'b0;
`ifdef MDU_DIV_EN
         is_div_q  <= 1'b0;
         neg_rem_q <= 1'b0;
         dzero_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         neg_q   <= neg_d;
         done_q  <= done_d;
`ifdef MDU_DIV_EN
         is_div_q  <= is_div_d;
         neg_rem_q <= neg_rem_d;
         dzero_q   <= dzero_d;
`endif
      end
   end

   assign o_done = done_q;
   assign o_hi   = hi_q;
   assign o_lo   = lo_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: cycle-level behavioural model plus directed literal checks.
// Honors MDU_DIV_EN the same way as the design.
module tb_mdu_sequencer;
   localparam int DW = 32;
   localparam logic [2:0] MULT = 3'b001, MULTU = 3'b010, DIV = 3'b011, DIVU = 3'b100,
                          MTHI = 3'b101, MTLO = 3'b110;
`ifdef MDU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic          i_clk = 1'b0, i_reset = 1'b1, i_valid = 1'b0, i_read_hilo = 1'b0;
   logic [2:0]    i_op = 3'b000;
   logic [DW-1:0] i_opA = '0, i_opB = '0;
   logic          o_busy, o_stall, o_done;
   logic [DW-1:0] o_hi, o_lo;

   int total = 0, bad = 0;
   bit cmp_en = 1'b0;

   mdu_sequencer #(.DATA_WIDTH(DW)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_op(i_op),
      .i_opA(i_opA), .i_opB(i_opB), .i_read_hilo(i_read_hilo),
      .o_busy(o_busy), .o_stall(o_stall), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo));

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result {HI,LO} of a multiply/divide command.
   function automatic logic [63:0] mdu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint p;
      int q, r;
      case (op)
         MULT: begin p = longint'($signed(a)) * longint'($signed(b)); return p; end
         MULTU: return {32'b0, a} * {32'b0, b};
         DIV: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
         end
         DIVU: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'h0;
      endcase
   endfunction

   // Model: cycles of busy remaining, pending result, architectural HI/LO.
   int          m_left = 0;
   logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
   logic        m_done = 0;

   always @(posedge i_clk) begin
      if (i_reset) begin
         m_left = 0; m_hi = 0; m_lo = 0; m_done = 0;
      end else begin
         m_done = 0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_hi = p_hi; m_lo = p_lo; m_done = 1;
            end
         end else if (i_valid) begin
            if (i_op == MULT || i_op == MULTU || (DIV_EN && (i_op == DIV || i_op == DIVU))) begin
               {p_hi, p_lo} = mdu_ref(i_op, i_opA, i_opB);
               m_left = DW + 1;
            end else if (i_op == MTHI) m_hi = i_opA;
            else if (i_op == MTLO) m_lo = i_opA;
         end
      end
   end

   always @(negedge i_clk) begin
      if (cmp_en) begin
         check("busy", o_busy, m_left > 0);
         check("done", o_done, m_done);
         check("hi", o_hi, m_hi);
         check("lo", o_lo, m_lo);
         check("stall", o_stall, (m_left > 0) && ((i_valid && i_op != 0 && i_op != 7) || i_read_hilo));
      end
   end

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      i_valid = 1'b1; i_op = op; i_opA = a; i_opB = b;
   endtask

   task automatic idle;
      i_valid = 1'b0; i_op = 3'b000;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (o_done !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check("done_within_budget", n < 100, 1);
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
      drive(op, a, b);
      tick();
      idle();
      wait_done(n);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return $urandom_range(0, 15);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      tick();
      cmp_en = 1'b1;
      tick();
      i_reset = 1'b0;
      check("reset_hi", o_hi, 0);
      check("reset_busy", o_busy, 0);

      run_cmd(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
      check("multu_latency", n, DW + 1);
      check("multu_hilo", {o_hi, o_lo}, 64'hFFFF_FFFE_0000_0001);
      tick();
      check("done_one_cycle", o_done, 0);

      run_cmd(MULT, -32'sd3, 32'd7, n);
      check("mult_neg_hilo", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFEB);

`ifdef MDU_DIV_EN
      run_cmd(DIV, -32'sd7, 32'd2, n);
      check("div_neg_hilo", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_cmd(DIVU, 32'd100, 32'd0, n);
      check("divu_zero_hilo", {o_hi, o_lo}, 64'h0000_0064_FFFF_FFFF);
      run_cmd(DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
      check("div_ovf_hilo", {o_hi, o_lo}, 64'h0000_0000_8000_0000);
`else
      drive(DIV, -32'sd7, 32'd2);
      tick();
      idle();
      check("nodiv_busy", o_busy, 0);
      tick();
      check("nodiv_done", o_done, 0);
      check("nodiv_hilo", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
`endif

      drive(MTLO, 32'h1234, 32'h0);
      tick();
      idle();
      check("mtlo_lo", o_lo, 32'h1234);
      check("mtlo_nodone", o_done, 0);

      // MFHI two cycles after a MULT accept
      drive(MULT, 32'd5, 32'd6);
      tick();
      idle();
      tick();
      i_read_hilo = 1'b1;
      #1;
      check("mfhi_stall", o_stall, 1);
      wait_done(n);
      check("mfhi_release", o_stall, 0);
      i_read_hilo = 1'b0;

      // second MULT held by the stall, accepted in the done cycle
      drive(MULT, 32'd5, 32'd6);
      tick();
      drive(MULT, 32'd7, 32'd8);
      #1;
      check("mult2_stall", o_stall, 1);
      wait_done(n);
      check("mult2_first_lo", o_lo, 30);
      check("mult2_nostall", o_stall, 0);
      tick();
      idle();
      check("mult2_accepted", o_busy, 1);
      wait_done(n);
      check("mult2_lo", {o_hi, o_lo}, 64'd56);

      // MTHI while busy
      drive(MULT, 32'd2, 32'd3);
      tick();
      drive(MTHI, 32'hABCD, 32'h0);
      wait_done(n);
      check("mthi_held_hi", o_hi, 0);
      tick();
      idle();
      check("mthi_hi", o_hi, 32'hABCD);
      check("mthi_lo", o_lo, 6);

      // reset during RUN
      drive(MULTU, 32'd9, 32'd9);
      tick();
      idle();
      repeat (10) tick();
      i_reset = 1'b1;
      tick();
      check("rst_busy", o_busy, 0);
      check("rst_hilo", {o_hi, o_lo}, 0);
      i_reset = 1'b0;
      tick();
      check("rst_nodone", o_done, 0);

      for (int c = 0; c < 3000; c++) begin
         i_reset     = ($urandom_range(0, 299) == 0);
         i_valid     = ($urandom_range(0, 3) == 0);
         i_op        = 3'($urandom_range(0, 7));
         i_opA       = pick();
         i_opB       = pick();
         i_read_hilo = ($urandom_range(0, 3) == 0);
         tick();
      end
      i_reset = 1'b0;
      idle();
      i_read_hilo = 1'b0;
      repeat (40) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
